// File: rtl/vga_pkg.sv
// Shared types and default geometry for the VGA framebuffer path.
package vga_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned V_ACTIVE_DEF = 480;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/vga_pixel_fifo.sv
// Synchronous show-ahead pixel FIFO with flush and occupancy count.
module vga_pixel_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 24
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             push_data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             head_o,
    output logic                         valid_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             pop_ok;

    // A pop on an empty FIFO is ignored.
    assign pop_ok  = pop_i && (count_q != '0);
    assign valid_o = (count_q != '0);
    assign count_o = count_q;
    // Head reads as zero when empty so flushed or stale entries never show.
    assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;

    // Pointer and occupancy tracking; flush empties the FIFO in one cycle.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_ok);
        end
    end

    // Pixel storage; contents only become visible through a valid head.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: deadline-bound scanout prefetch vs best-effort writer.
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
    parameter int unsigned ADDR_W     = 19,
    parameter int unsigned DATA_W     = 24,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned LOW_WATER  = 8,
    parameter int unsigned READ_LAT   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              pix_rd,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    output logic              underrun,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned INF_W = $clog2(READ_LAT + 1);
    localparam int unsigned CR_W  = $clog2(FIFO_DEPTH + READ_LAT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

    fetch_state_e        state_q;
    logic [ADDR_W-1:0]   fetch_addr_q;
    logic [READ_LAT-1:0] vld_q;
    logic [READ_LAT-1:0] vld_d;
    logic                underrun_q;

    logic [CNT_W-1:0]    fifo_count;
    logic [INF_W-1:0]    inflight;
    logic [CR_W-1:0]     credit;
    logic                eligible;
    logic                disp_rd;
    logic                wr_gnt;
    logic                restart;
    logic                fifo_push;

    // A new frame_start during fetch restarts the frame from address 0.
    assign restart   = frame_start && (state_q == FETCH);
    assign fifo_push = vld_q[READ_LAT-1] && !restart;
    assign underrun  = underrun_q;

    // Outstanding reads plus buffered pixels bound how far ahead we may fetch.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LAT; i++) begin
            inflight = inflight + INF_W'(vld_q[i]);
        end
        credit = CR_W'(fifo_count) + CR_W'(inflight);
    end

    // Per-cycle grant: urgent display, then writer, then opportunistic display.
    always_comb begin
        eligible  = (state_q == FETCH) && (credit < CR_W'(FIFO_DEPTH));
        disp_rd   = !reset && eligible && ((credit < CR_W'(LOW_WATER)) || !wr_valid);
        wr_gnt    = !reset && wr_valid && !disp_rd;
        wr_ready  = wr_gnt;
        mem_en    = disp_rd || wr_gnt;
        mem_we    = wr_gnt;
        mem_addr  = '0;
        mem_wdata = '0;
        if (disp_rd) begin
            mem_addr = fetch_addr_q;
        end else if (wr_gnt) begin
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
        end
    end

    // Read-latency tag pipeline: new display reads enter at bit 0.
    always_comb begin
        vld_d    = '0;
        vld_d[0] = disp_rd;
        for (int i = 1; i < READ_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    // Fetch sequencer, read tags and sticky underrun flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            fetch_addr_q <= '0;
            vld_q        <= '0;
            underrun_q   <= 1'b0;
        end else begin
            vld_q <= restart ? '0 : vld_d;
            if (pix_rd && !pix_valid) begin
                underrun_q <= 1'b1;
            end
            case (state_q)
                IDLE, DONE: begin
                    if (frame_start) begin
                        state_q      <= FETCH;
                        fetch_addr_q <= '0;
                    end
                end
                FETCH: begin
                    if (restart) begin
                        fetch_addr_q <= '0;
                    end else if (disp_rd) begin
                        fetch_addr_q <= fetch_addr_q + ADDR_W'(1);
                        if (fetch_addr_q == LAST_ADDR) begin
                            state_q <= DONE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    vga_pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (restart),
        .push_i      (fifo_push),
        .push_data_i (mem_rdata),
        .pop_i       (pix_rd),
        .head_o      (pix_data),
        .valid_o     (pix_valid),
        .count_o     (fifo_count)
    );

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a small frame and a behavioural RAM.
module tb_vga_fb_arbiter;
    import vga_pkg::*;

    localparam int unsigned H_ACT  = 40;
    localparam int unsigned V_ACT  = 30;
    localparam int unsigned ADDR_W = 19;
    localparam int unsigned DATA_W = 24;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned LOWW   = 8;
    localparam int unsigned LAT    = 2;
    localparam int LAST = int'(H_ACT * V_ACT) - 1;

    logic              clk = 1'b0;
    logic              reset, frame_start, pix_rd, wr_valid;
    logic [DATA_W-1:0] pix_data, wr_data, mem_wdata, mem_rdata;
    logic              pix_valid, underrun, wr_ready, mem_en, mem_we;
    logic [ADDR_W-1:0] wr_addr, mem_addr;

    always #5 clk = ~clk;

    vga_fb_arbiter #(
        .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .FIFO_DEPTH(DEPTH), .LOW_WATER(LOWW), .READ_LAT(LAT)
    ) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .pix_rd(pix_rd),
        .pix_data(pix_data), .pix_valid(pix_valid), .underrun(underrun),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Model RAM: mem[a] = a, returned LAT cycles after the read cycle.
    logic [ADDR_W-1:0] rpipe [LAT];
    always @(posedge clk) begin
        rpipe[0] <= mem_addr;
        for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_rdata = DATA_W'(rpipe[LAT-1]);

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: cycle at which each issued read becomes visible.
    int q_ready[$];
    bit m_fetching   = 1'b0;
    bit exp_underrun = 1'b0;
    int exp_fetch = 0, exp_pix = 0, cyc = 0;
    bit drain = 1'b0, force_rd = 1'b0;
    int obs_reads = 0, obs_wr = 0, last_rd_addr = -1, nwr = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic bit model_valid();
        return (q_ready.size() > 0) && (q_ready[0] <= cyc);
    endfunction

    task automatic set_writer();
        pixel_t p;
        p.r = 8'(nwr);
        p.g = 8'(nwr * 3);
        p.b = 8'hC3;
        wr_data = p;
        wr_addr = ADDR_W'(20000 + nwr * 7);
    endtask

    // One clock cycle: check DUT against model mid-cycle, then advance model.
    task automatic tick();
        int credit;
        bit valid_exp, elig, rd_exp, wr_exp;
        @(negedge clk);
        credit    = q_ready.size();
        valid_exp = model_valid();
        elig      = m_fetching && (credit < int'(DEPTH)) && !reset;
        rd_exp    = elig && ((credit < int'(LOWW)) || !wr_valid);
        wr_exp    = !reset && wr_valid && !rd_exp;
        check_eq("pix_valid", 32'(pix_valid), 32'(valid_exp));
        check_eq("underrun", 32'(underrun), 32'(exp_underrun));
        check_eq("wr_ready", 32'(wr_ready), 32'(wr_exp));
        check_eq("mem_en", 32'(mem_en), 32'(rd_exp || wr_exp));
        if (rd_exp) begin
            check_eq("rd_we", 32'(mem_we), 32'(0));
            check_eq("rd_addr", 32'(mem_addr), 32'(exp_fetch));
        end
        if (wr_exp) begin
            check_eq("wr_we", 32'(mem_we), 32'(1));
            check_eq("wr_addr", 32'(mem_addr), 32'(wr_addr));
            check_eq("wr_data", 32'(mem_wdata), 32'(wr_data));
        end
        if (pix_rd && valid_exp) check_eq("pix_data", 32'(pix_data), 32'(exp_pix));
        if (mem_en && !mem_we) begin obs_reads++; last_rd_addr = int'(mem_addr); end
        if (mem_en && mem_we) obs_wr++;
        if (pix_rd && valid_exp) begin void'(q_ready.pop_front()); exp_pix++; end
        if (pix_rd && !valid_exp && !reset) exp_underrun = 1'b1;
        if (rd_exp) begin
            q_ready.push_back(cyc + int'(LAT) + 1);
            if (exp_fetch == LAST) m_fetching = 1'b0;
            exp_fetch++;
        end
        if (frame_start && !reset) begin
            if (m_fetching) q_ready.delete();
            m_fetching = 1'b1;
            exp_fetch  = 0;
            exp_pix    = 0;
        end
        if (reset) begin
            q_ready.delete();
            m_fetching   = 1'b0;
            exp_underrun = 1'b0;
            exp_fetch    = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (wr_exp) begin nwr++; set_writer(); end
    endtask

    task automatic step();
        pix_rd = force_rd || (drain && model_valid());
        tick();
    endtask

    initial begin
        reset = 1'b1; frame_start = 1'b0; pix_rd = 1'b0; wr_valid = 1'b0;
        wr_addr = '0; wr_data = '0;
        repeat (3) step();
        reset = 1'b0;
        #1;
        check_eq("rst_state", 32'(dut.state_q), 32'(IDLE));
        check_eq("rst_pix_valid", 32'(pix_valid), 32'(0));
        check_eq("rst_underrun", 32'(underrun), 32'(0));
        check_eq("rst_pix_data", 32'(pix_data), 32'(0));
        check_eq("rst_mem_en", 32'(mem_en), 32'(0));
        check_eq("rst_mem_we", 32'(mem_we), 32'(0));
        check_eq("rst_mem_addr", 32'(mem_addr), 32'(0));
        check_eq("rst_mem_wdata", 32'(mem_wdata), 32'(0));

        // Fill with no consumer: reads stop once credit reaches FIFO depth.
        frame_start = 1'b1; step(); frame_start = 1'b0;
        repeat (25) step();
        check_eq("fill_count", 32'(dut.fifo_count), 32'(DEPTH));
        check_eq("fill_stop", 32'(mem_en), 32'(0));
        check_eq("fill_head", 32'(pix_data), 32'(0));

        // Steady scanout, no writer.
        drain = 1'b1;
        for (int i = 0; i < 2000 && exp_fetch < 600; i++) step();
        check_eq("drain_to_600", 32'(last_rd_addr), 32'(599));

        // Writer contends while the display drains.
        wr_valid = 1'b1; set_writer();
        for (int i = 0; i < 1000 && exp_fetch < 800; i++) step();
        drain = 1'b0;
        repeat (20) step();
        check_eq("wr_credit_hold", 32'(dut.credit), 32'(LOWW));
        check_eq("wr_ready_hold", 32'(wr_ready), 32'(1));
        drain = 1'b1;
        for (int i = 0; i < 1000 && exp_fetch < 950; i++) step();
        check_eq("writes_seen", 32'(obs_wr != 0), 32'(1));
        wr_valid = 1'b0;
        for (int i = 0; i < 1000 && exp_fetch < 1000; i++) step();

        // Restart mid-frame with two reads outstanding.
        check_eq("inflight_pre", 32'(dut.inflight), 32'(2));
        frame_start = 1'b1;
        #1;
        check_eq("restart_rd_addr", 32'(mem_addr), 32'(1000));
        step(); frame_start = 1'b0;
        check_eq("restart_empty", 32'(pix_valid), 32'(0));
        check_eq("restart_state", 32'(dut.state_q), 32'(FETCH));
        obs_reads = 0;
        for (int i = 0; i < 4000 && m_fetching; i++) step();
        for (int i = 0; i < 60 && q_ready.size() > 0; i++) step();
        check_eq("done_state", 32'(dut.state_q), 32'(DONE));
        check_eq("frame_reads", 32'(obs_reads), 32'(LAST + 1));
        check_eq("last_addr", 32'(last_rd_addr), 32'(LAST));
        check_eq("no_underrun", 32'(underrun), 32'(0));

        // Underrun from DONE, then restart the frame.
        drain = 1'b0; force_rd = 1'b1; step(); force_rd = 1'b0;
        check_eq("underrun_set", 32'(underrun), 32'(1));
        frame_start = 1'b1; step(); frame_start = 1'b0;
        repeat (10) step();

        // Reset during FETCH with a writer request pending.
        reset = 1'b1; wr_valid = 1'b1; set_writer();
        #1;
        check_eq("rst_cycle_mem_en", 32'(mem_en), 32'(0));
        check_eq("rst_cycle_wr_ready", 32'(wr_ready), 32'(0));
        step();
        reset = 1'b0; wr_valid = 1'b0;
        #1;
        check_eq("post_rst_mem_en", 32'(mem_en), 32'(0));
        check_eq("post_rst_pix_valid", 32'(pix_valid), 32'(0));
        check_eq("post_rst_underrun", 32'(underrun), 32'(0));
        check_eq("post_rst_state", 32'(dut.state_q), 32'(IDLE));

        // Underrun before any frame_start is sticky across a new frame.
        force_rd = 1'b1; step(); force_rd = 1'b0;
        check_eq("idle_underrun", 32'(underrun), 32'(1));
        frame_start = 1'b1; step(); frame_start = 1'b0;
        drain = 1'b1;
        repeat (40) step();
        check_eq("underrun_sticky", 32'(underrun), 32'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port framebuffer memory between two clients: display scanout, which is real-time and deadline-bound, and a drawing writer, which is best-effort.
- Prefetches the frame linearly into a small show-ahead pixel FIFO that the VGA timing generator drains during active video.
- Gives the writer every memory cycle the display does not urgently need.
- Sits between the timing generator, the framebuffer RAM and the drawing engine, all in the pixel clock domain.

Parameters:
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
ADDR_W, 19, framebuffer word address width (must hold H_ACTIVE*V_ACTIVE-1)
DATA_W, 24, pixel width {r,g,b}
FIFO_DEPTH, 16, pixel FIFO entries (power of 2)
LOW_WATER, 8, urgency threshold on fifo_count+inflight
READ_LAT, 2, fixed memory read latency in cycles (>=1)

Ports:
clk  in  1  pixel clock
reset  in  1  reset, synchronous, active-high
frame_start  in  1  one-cycle pulse during vertical blank; starts fetch of a new frame
pix_rd  in  1  display consumes head pixel (asserted while blank_n high)
pix_data  out  DATA_W  FIFO head pixel, valid when pix_valid
pix_valid  out  1  FIFO non-empty
underrun  out  1  sticky: pix_rd seen with FIFO empty
wr_valid  in  1  writer request
wr_ready  out  1  writer granted this cycle (combinational)
wr_addr  in  ADDR_W  writer address
wr_data  in  DATA_W  writer data
mem_en  out  1  memory access this cycle
mem_we  out  1  1=write, 0=read
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  write data
mem_rdata  in  DATA_W  read data, valid READ_LAT cycles after the read cycle

Behaviour:
- Reset values:
  - state=IDLE, fetch_addr=0, FIFO empty, inflight pipeline cleared.
  - pix_valid=0, underrun=0, pix_data=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- States:
  - IDLE: no display reads; frame_start -> FETCH, fetch_addr=0.
  - FETCH: display reads are eligible. When the read of address H_ACTIVE*V_ACTIVE-1 is issued -> DONE.
  - DONE: no display reads; frame_start -> FETCH, fetch_addr=0.
- credit = fifo_count + inflight. A display read is eligible only in FETCH with credit < FIFO_DEPTH. The FIFO therefore never overflows.
- Arbitration per cycle, combinational:
  1. Eligible and credit < LOW_WATER: display read.
  2. Else wr_valid: writer write, wr_ready=1.
  3. Else eligible: display read.
  4. Else mem_en=0.
- wr_ready=0 whenever the display takes the cycle. The writer holds addr/data until accepted.
- Memory outputs are combinational from the grant. mem_addr is fetch_addr for reads and wr_addr for writes. Each display read increments fetch_addr by 1.
- Read tracking:
  - A READ_LAT-deep valid shift register tags display reads.
  - When the tail valid bit is set, mem_rdata is pushed into the FIFO that cycle.
  - inflight = popcount of the shift register.
- FIFO is show-ahead: pix_data = head.
  - pix_rd && pix_valid pops.
  - Push and pop in the same cycle leaves the count unchanged.
  - Push into an empty FIFO makes pix_valid=1 on the next cycle.
- pix_rd with pix_valid=0 sets underrun (held until reset) and pops nothing.
- frame_start while in FETCH (frame restart):
  - FIFO is flushed.
  - All inflight valid bits are cleared; late data is dropped.
  - fetch_addr=0, state stays FETCH.
  - The same cycle's arbitration uses the pre-flush state.
  - The writer is never dropped.
- Reset mid-operation aborts everything. A writer request accepted in the reset cycle is not issued.
- Address arithmetic is unsigned ADDR_W. The last fetch address is the compile-time constant H_ACTIVE*V_ACTIVE-1.

Decomposition:
- Package vga_pkg holds:
  - H_ACTIVE/V_ACTIVE defaults
  - pixel_t (DATA_W struct r,g,b)
  - fetch_state_e {IDLE, FETCH, DONE}
- One sub-module: vga_pixel_fifo (sync show-ahead FIFO with flush, count output).

Test Plan:
- Reset, no writer; frame_start -> reads at addr 0,1,2... every cycle until credit=16. Data from a model RAM (mem[a]=a) appears at pix_data 0,1,2 in order with no gaps. Then DONE at addr 307199.
- wr_valid held constantly, display draining 1 pixel/cycle after fill: writer is granted only while credit>=8. underrun stays 0, no read address skipped.
- credit<8 with wr_valid=1: display wins, wr_ready=0. Once credit>=8 the writer is granted, and mem_we=1 with the exact wr_addr/wr_data.
- pix_rd asserted with FIFO empty (before any frame_start) -> underrun=1 and it stays 1 through a later frame_start.
- frame_start mid-frame at fetch_addr=1000 with 2 reads inflight: FIFO flushes, the dropped data never reaches pix_data, and the next read is addr 0.
- Reset during FETCH: next cycle mem_en=0, pix_valid=0, underrun=0, state=IDLE.
